// File: rtl/datapath_run_ctrl.sv
// Run/step controller for the pipelined Datapath: owns its reset and clock enable,
// debounces the step button, limits free-run length and scans the display selectors.
module datapath_run_ctrl #(
  parameter int RST_CYCLES      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_CYCLES      = 13,
  parameter int SCAN_DWELL      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        scan_en,
  input  logic [1:0]  led_sel_sw,
  input  logic [3:0]  ssd_sel_sw,
  output logic        cpu_rst,
  output logic        cpu_en,
  output logic [1:0]  led_sel,
  output logic [3:0]  ssd_sel,
  output logic [15:0] cycle_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_INIT = 3'b000,
    ST_IDLE = 3'b001,
    ST_STEP = 3'b010,
    ST_RUN  = 3'b011,
    ST_DONE = 3'b100
  } state_t;

  localparam int INIT_W = $clog2(RST_CYCLES + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W   = $clog2(SCAN_DWELL + 1);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]   SCAN_LAST = SC_W'(SCAN_DWELL - 1);
  localparam logic [16:0]       LIMIT     = 17'(MAX_CYCLES);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_run_sync;
  logic [1:0]         r_btn_sync;
  logic [DB_W-1:0]    r_db_cnt;
  logic               r_btn_db;
  logic               r_btn_db_q;
  logic [INIT_W-1:0]  r_init_cnt;
  logic [15:0]        r_cycle_cnt;
  logic [SC_W-1:0]    r_scan_cnt;
  logic [1:0]         r_led_sel;
  logic [3:0]         r_ssd_sel;

  logic               w_run_s;
  logic               w_btn_s;
  logic               w_step_pulse;
  logic               w_cpu_en;
  logic [16:0]        w_cnt_inc;
  logic               w_limit;

  assign w_run_s      = r_run_sync[1];
  assign w_btn_s      = r_btn_sync[1];
  assign w_step_pulse = r_btn_db & ~r_btn_db_q;

  // NOTE: every flop here uses <= so all state updates see pre-edge values; the
  // async reset clears every register, including synchronizers and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_sync <= '0;
      r_btn_sync <= '0;
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
    end else begin
      r_run_sync <= {r_run_sync[0], run_sw};
      r_btn_sync <= {r_btn_sync[0], step_btn};
      r_btn_db_q <= r_btn_db;
      // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
      if (w_btn_s == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt <= '0;
        r_btn_db <= w_btn_s;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_cpu_en  = (r_state == ST_STEP) || (r_state == ST_RUN);
  assign w_cnt_inc = {1'b0, r_cycle_cnt} + 17'd1;
  assign w_limit   = (MAX_CYCLES != 0) && (w_cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT && r_init_cnt != INIT_LAST) begin
        r_init_cnt <= r_init_cnt + INIT_W'(1);
      end
      if (w_cpu_en) begin
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
    end
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == INIT_LAST) w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_run_s)           w_next = ST_RUN;
        else if (w_step_pulse) w_next = ST_STEP;
      end
      ST_STEP: w_next = w_limit ? ST_DONE : ST_IDLE;
      ST_RUN: begin
        if (w_limit)       w_next = ST_DONE;
        else if (!w_run_s) w_next = ST_IDLE;
      end
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_INIT;
    endcase
  end

  // Selectors scan independently of the FSM; ssd_sel is the fast digit, led_sel the slow one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_led_sel  <= '0;
      r_ssd_sel  <= '0;
    end else if (!scan_en) begin
      r_scan_cnt <= '0;
      r_led_sel  <= led_sel_sw;
      r_ssd_sel  <= ssd_sel_sw;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_ssd_sel  <= r_ssd_sel + 4'd1;
      if (r_ssd_sel == 4'hF) r_led_sel <= r_led_sel + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + SC_W'(1);
    end
  end

  assign cpu_rst   = (r_state == ST_INIT);
  assign cpu_en    = w_cpu_en;
  assign led_sel   = r_led_sel;
  assign ssd_sel   = r_ssd_sel;
  assign cycle_cnt = r_cycle_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Directed bench for datapath_run_ctrl: reset/INIT timing, debounced stepping,
// run limit and pause, async reset mid-run, selector scan and manual selectors.
module tb_datapath_run_ctrl;

  localparam logic [2:0] S_INIT = 3'b000;
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN  = 3'b011;
  localparam logic [2:0] S_DONE = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        scan_en = 1'b0;
  logic [1:0]  led_sel_sw = 2'b00;
  logic [3:0]  ssd_sel_sw = 4'b0000;
  logic        cpu_rst;
  logic        cpu_en;
  logic [1:0]  led_sel;
  logic [3:0]  ssd_sel;
  logic [15:0] cycle_cnt;
  logic [2:0]  state;

  int n_pass  = 0;
  int n_total = 0;
  int en_seen = 0;

  typedef struct {
    logic       scan_en;
    logic [1:0] led_sw;
    logic [3:0] ssd_sw;
    logic [1:0] exp_led;
    logic [3:0] exp_ssd;
  } vec_t;

  vec_t vecs[4];

  datapath_run_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .scan_en    (scan_en),
    .led_sel_sw (led_sel_sw),
    .ssd_sel_sw (ssd_sel_sw),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .led_sel    (led_sel),
    .ssd_sel    (ssd_sel),
    .cycle_cnt  (cycle_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_en) en_seen++;
  endtask

  task automatic wait_state(input string name, input logic [2:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state == exp) break;
      tick();
    end
    check(name, 32'(state), 32'(exp));
  endtask

  // Releases rst off-edge and expects cpu_rst high for exactly 4 edges.
  task automatic release_and_check_init(input string tag);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check({tag, "_cpu_rst"}, 32'(cpu_rst), (i < 4) ? 32'd1 : 32'd0);
    end
    check({tag, "_state_idle"}, 32'(state), 32'(S_IDLE));
    check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #1 rst = 1'b0;
    tick();
    release_and_check_init(tag);
  endtask

  task automatic press(input int hold, input int after);
    step_btn = 1'b1;
    repeat (hold) tick();
    step_btn = 1'b0;
    repeat (after) tick();
  endtask

  initial begin
    int base;
    int first_en;
    int last_en;
    int steps;
    int exp_led;
    int exp_ssd;

    vecs[0] = '{1'b0, 2'b10, 4'b0111, 2'd2, 4'd7};
    vecs[1] = '{1'b0, 2'b11, 4'b1111, 2'd3, 4'd15};
    vecs[2] = '{1'b0, 2'b00, 4'b0000, 2'd0, 4'd0};
    vecs[3] = '{1'b0, 2'b01, 4'b1010, 2'd1, 4'd10};

    // Power-up reset
    #2;
    check("rst_state", 32'(state), 32'(S_INIT));
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_led_sel", 32'(led_sel), 32'd0);
    check("rst_ssd_sel", 32'(ssd_sel), 32'd0);
    tick();
    tick();
    check("rst_held_state", 32'(state), 32'(S_INIT));
    release_and_check_init("init0");

    // Short glitches are rejected
    base = en_seen;
    for (int g = 0; g < 3; g++) press(2, 3);
    repeat (10) tick();
    check("glitch_no_en", 32'(en_seen - base), 32'd0);
    check("glitch_cnt", 32'(cycle_cnt), 32'd0);
    check("glitch_state", 32'(state), 32'(S_IDLE));

    // Held presses each give exactly one step
    base = en_seen;
    press(10, 15);
    check("step1_en", 32'(en_seen - base), 32'd1);
    check("step1_cnt", 32'(cycle_cnt), 32'd1);
    check("step1_state", 32'(state), 32'(S_IDLE));
    base = en_seen;
    press(10, 15);
    check("step2_en", 32'(en_seen - base), 32'd1);
    check("step2_cnt", 32'(cycle_cnt), 32'd2);

    // Run pause: 5 cycles of run_sw, 3-edge latency to RUN
    base = en_seen;
    run_sw = 1'b1;
    tick();
    tick();
    check("run_lat_2edges", 32'(state), 32'(S_IDLE));
    tick();
    check("run_lat_3edges", 32'(state), 32'(S_RUN));
    check("run_first_en", 32'(cpu_en), 32'd1);
    tick();
    tick();
    run_sw = 1'b0;
    wait_state("pause_idle", S_IDLE, 20);
    check("pause_en_cycles", 32'(en_seen - base), 32'd5);
    check("pause_cnt", 32'(cycle_cnt), 32'd7);
    check("pause_cpu_en", 32'(cpu_en), 32'd0);

    // Resume to the limit
    base = en_seen;
    run_sw = 1'b1;
    wait_state("resume_done", S_DONE, 40);
    check("resume_en_cycles", 32'(en_seen - base), 32'd6);
    check("resume_cnt", 32'(cycle_cnt), 32'd13);
    check("resume_cpu_en", 32'(cpu_en), 32'd0);

    // DONE ignores run and step
    base = en_seen;
    run_sw = 1'b0;
    repeat (6) tick();
    run_sw = 1'b1;
    repeat (6) tick();
    run_sw = 1'b0;
    press(10, 15);
    check("done_no_en", 32'(en_seen - base), 32'd0);
    check("done_state", 32'(state), 32'(S_DONE));
    check("done_cnt", 32'(cycle_cnt), 32'd13);

    // Fresh run to limit: 13 consecutive enabled cycles
    do_reset("init1");
    first_en = -1;
    last_en  = -1;
    base = en_seen;
    run_sw = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (cpu_en) begin
        if (first_en < 0) first_en = t;
        last_en = t;
      end
      if (state == S_DONE) break;
    end
    check("limit_state", 32'(state), 32'(S_DONE));
    check("limit_en_cycles", 32'(en_seen - base), 32'd13);
    check("limit_en_span", 32'(last_en - first_en + 1), 32'd13);
    check("limit_cnt", 32'(cycle_cnt), 32'd13);
    check("limit_cpu_en", 32'(cpu_en), 32'd0);

    // Async reset mid-run at cycle_cnt=6
    run_sw = 1'b0;
    do_reset("init2");
    run_sw = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (cycle_cnt == 16'd6) break;
      tick();
    end
    check("mid_run_cnt6", 32'(cycle_cnt), 32'd6);
    check("mid_run_en", 32'(cpu_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_cpu_en", 32'(cpu_en), 32'd0);
    check("async_cpu_rst", 32'(cpu_rst), 32'd1);
    check("async_cnt", 32'(cycle_cnt), 32'd0);
    check("async_state", 32'(state), 32'(S_INIT));
    #1;
    release_and_check_init("init3");
    tick();
    check("restart_run", 32'(state), 32'(S_RUN));
    run_sw = 1'b0;

    // Scan mode from (0,0)
    led_sel_sw = 2'b00;
    ssd_sel_sw = 4'b0000;
    tick();
    check("pre_scan_led", 32'(led_sel), 32'd0);
    check("pre_scan_ssd", 32'(ssd_sel), 32'd0);
    scan_en = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      steps   = t / 3;
      exp_ssd = steps % 16;
      exp_led = (steps / 16) % 4;
      check($sformatf("scan_t%0d", t), {24'd0, 2'(led_sel), 4'(ssd_sel)},
            32'((exp_led << 4) | exp_ssd));
      if (t == 192) check("scan_wrap_00", {28'd0, 2'(led_sel), 2'd0} | 32'(ssd_sel), 32'd0);
    end

    // Manual selectors, 1-cycle latency (first row also covers scan_en 1->0)
    steps   = 200 / 3;
    exp_ssd = steps % 16;
    exp_led = (steps / 16) % 4;
    for (int v = 0; v < 4; v++) begin
      scan_en    = vecs[v].scan_en;
      led_sel_sw = vecs[v].led_sw;
      ssd_sel_sw = vecs[v].ssd_sw;
      #1;
      check($sformatf("man%0d_hold_led", v), 32'(led_sel), 32'(exp_led));
      check($sformatf("man%0d_hold_ssd", v), 32'(ssd_sel), 32'(exp_ssd));
      tick();
      check($sformatf("man%0d_led", v), 32'(led_sel), 32'(vecs[v].exp_led));
      check($sformatf("man%0d_ssd", v), 32'(ssd_sel), 32'(vecs[v].exp_ssd));
      exp_led = int'(vecs[v].exp_led);
      exp_ssd = int'(vecs[v].exp_ssd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
